term_rx: RTL and testbench

TERM_RX -- requirements
Module: term_rx

---
 rtl/router_pkg.sv | 24 ++
 rtl/rx_fifo.sv | 55 +++++
 rtl/term_rx.sv | 104 ++++++++++
 tb/tb_term_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared mesh-router definitions: packet field offsets, terminal receive FSM
// states and the width of the terminal's statistics counters.
package router_pkg;

  // Field positions are given as offsets below the packet MSB, so any
  // pckg_sz can use them: field msb = pckg_sz - <offset>.
  localparam int NXT_W        = 8;
  localparam int ID_W         = 4;
  localparam int NXT_MSB_OFS  = 1;
  localparam int ROW_MSB_OFS  = 9;
  localparam int COL_MSB_OFS  = 13;
  localparam int MODE_OFS     = 17;
  localparam int PAYLOAD_OFS  = 18;
  localparam int BCST_LSB     = 18;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    HOLD = 2'd2
  } rx_state_t;

endpackage

// File: rtl/rx_fifo.sv
// Client-side receive buffer: FIFO with a combinational head and
// free-running pointers that wrap modulo depth (depth is a power of two).
module rx_fifo #(
  parameter int width = 41,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             rd_en,
  output logic [width-1:0] rd_data,
  output logic             valid,
  output logic             full
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  // Reads of an empty buffer and writes into a full one are dropped.
  assign do_rd = rd_en && (count != '0);
  assign do_wr = wr_en && (count != DEPTH_C);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign valid   = (count != '0);
  assign full    = (count == DEPTH_C);

endmodule

// File: rtl/term_rx.sv
// Mesh terminal receiver: pops packets from the router terminal output,
// keeps broadcast/addressed ones in a client FIFO and counts misroutes.
module term_rx
  import router_pkg::*;
#(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int id_row     = 0,
  parameter int id_column  = 0,
  parameter logic [pckg_sz-19:0] bdcst = {(pckg_sz-18){1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_bcst,
  input  logic               rx_ready,
  output logic [CNT_W-1:0]   misroute_cnt,
  output logic               full
);

  localparam logic [ID_W-1:0] ROW_ID = ID_W'(id_row);
  localparam logic [ID_W-1:0] COL_ID = ID_W'(id_column);

  rx_state_t state;

  logic is_bcst;
  logic is_match;
  logic take;
  logic wr_en;
  logic rd_en;
  logic [pckg_sz:0] head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Classification looks at data_out only on the edge that leaves POP.
  assign is_bcst  = (data_out[pckg_sz-1:BCST_LSB] == bdcst);
  assign is_match = (data_out[pckg_sz-ROW_MSB_OFS -: ID_W] == ROW_ID) &&
                    (data_out[pckg_sz-COL_MSB_OFS -: ID_W] == COL_ID);
  assign take     = (state == POP);
  assign wr_en    = take && (is_bcst || is_match);
  assign rd_en    = rx_valid && rx_ready;

  // The entry check on !full is what keeps the buffer from overflowing:
  // nothing else writes while a pop is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pop   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pndng && !full) begin
            state <= POP;
            pop   <= 1'b1;
          end
        end
        POP: begin
          state <= HOLD;
          pop   <= 1'b0;
        end
        HOLD: begin
          state <= IDLE;
          pop   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          pop   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misroute_cnt <= '0;
    end else if (take && !is_bcst && !is_match) begin
      misroute_cnt <= sat_inc(misroute_cnt);
    end
  end

  rx_fifo #(
    .width (pckg_sz + 1),
    .depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data ({is_bcst, data_out}),
    .rd_en   (rd_en),
    .rd_data (head),
    .valid   (rx_valid),
    .full    (full)
  );

  assign rx_data = head[pckg_sz-1:0];
  assign rx_bcst = head[pckg_sz];

endmodule

// File: tb/tb_term_rx.sv
// Directed bench for term_rx: a table of single-packet vectors plus
// hand-written sequences for saturation, backpressure, overlap and reset.
module tb_term_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng;
  logic [39:0] data_out;
  logic        pop;
  logic        rx_valid;
  logic [39:0] rx_data;
  logic        rx_bcst;
  logic        rx_ready;
  logic [7:0]  misroute_cnt;
  logic        full;

  int n_vec = 0;
  int n_err = 0;

  // Router terminal model: packets are queued by the stimulus process and
  // removed by the model process one delta after a pop edge.
  logic [39:0] pkt_mem [1024];
  int wr_idx = 0;
  int rd_idx = 0;

  assign pndng    = (rd_idx != wr_idx);
  assign data_out = pkt_mem[rd_idx % 1024];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pop) begin
      #1;
      rd_idx = rd_idx + 1;
    end
  end

  term_rx #(
    .pckg_sz    (40),
    .fifo_depth (4),
    .id_row     (1),
    .id_column  (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pndng        (pndng),
    .data_out     (data_out),
    .pop          (pop),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_bcst      (rx_bcst),
    .rx_ready     (rx_ready),
    .misroute_cnt (misroute_cnt),
    .full         (full)
  );

  typedef struct {
    string       name;
    logic [39:0] pkt;
    logic        acc;
    logic        bcst;
    logic [7:0]  mis;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [39:0] mk(input logic [7:0] nxt, input logic [3:0] r,
                                     input logic [3:0] c, input logic m,
                                     input logic [22:0] pl);
    return {nxt, r, c, m, pl};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [39:0] p);
    pkt_mem[wr_idx % 1024] = p;
    wr_idx = wr_idx + 1;
  endtask

  task automatic run_cycles(input int n, output int pops, output logic v_next);
    logic prev;
    prev   = 1'b0;
    pops   = 0;
    v_next = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (prev) v_next = rx_valid;
      prev = pop;
      if (pop) pops++;
    end
  endtask

  task automatic read_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_pop(input string nm);
    int i;
    for (i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pop) break;
    end
    check({nm, "_pop_seen"}, 64'(pop), 64'd1);
  endtask

  initial begin
    int          pops;
    logic        vn;
    logic [39:0] bp [6];
    logic [39:0] pa, pb, pc;

    tbl[0] = '{"match",      mk(8'h00, 4'd1, 4'd1, 1'b0, 23'h012345), 1'b1, 1'b0, 8'd0};
    tbl[1] = '{"misroute20", mk(8'h00, 4'd2, 4'd0, 1'b0, 23'h000111), 1'b0, 1'b0, 8'd1};
    tbl[2] = '{"broadcast",  {22'h3FFFFF, 18'h00ABC},                 1'b1, 1'b1, 8'd1};
    tbl[3] = '{"match_mode", mk(8'h55, 4'd1, 4'd1, 1'b1, 23'h7FFFFF), 1'b1, 1'b0, 8'd1};
    tbl[4] = '{"misroute12", mk(8'h00, 4'd1, 4'd2, 1'b0, 23'h000222), 1'b0, 1'b0, 8'd2};
    tbl[5] = '{"misroute01", mk(8'h00, 4'd0, 4'd1, 1'b0, 23'h000333), 1'b0, 1'b0, 8'd3};
    tbl[6] = '{"near_bcst",  {22'h3FFFFE, 18'h00001},                 1'b0, 1'b0, 8'd4};
    tbl[7] = '{"match_ffx",  mk(8'hFF, 4'd1, 4'd1, 1'b1, 23'h7C0000), 1'b1, 1'b0, 8'd4};

    reset    = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pop",      64'(pop),          64'd0);
    check("rst_rx_valid", 64'(rx_valid),     64'd0);
    check("rst_full",     64'(full),         64'd0);
    check("rst_misroute", 64'(misroute_cnt), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      push(tbl[v].pkt);
      run_cycles(6, pops, vn);
      check({tbl[v].name, "_pops"},      64'(pops),         64'd1);
      check({tbl[v].name, "_valid_lat"}, 64'(vn),           64'(tbl[v].acc));
      check({tbl[v].name, "_rx_valid"},  64'(rx_valid),     64'(tbl[v].acc));
      if (tbl[v].acc) begin
        check({tbl[v].name, "_rx_data"}, 64'(rx_data),      64'(tbl[v].pkt));
        check({tbl[v].name, "_rx_bcst"}, 64'(rx_bcst),      64'(tbl[v].bcst));
      end
      check({tbl[v].name, "_misroute"},  64'(misroute_cnt), 64'(tbl[v].mis));
      if (rx_valid) read_one();
      check({tbl[v].name, "_drained"},   64'(rx_valid),     64'd0);
    end

    // 300 misroutes on top of the 4 already counted: counter must stick at 255.
    for (int i = 0; i < 300; i++) push(mk(8'h00, 4'd2, 4'd0, 1'b0, 23'(i)));
    pops = 0;
    for (int i = 0; i < 1500 && rd_idx != wr_idx; i++) begin
      @(negedge clk);
      if (pop) pops++;
    end
    repeat (3) @(negedge clk);
    check("sat_drained",  64'(rd_idx == wr_idx), 64'd1);
    check("sat_pops",     64'(pops),             64'd300);
    check("sat_misroute", 64'(misroute_cnt),     64'd255);
    check("sat_rx_valid", 64'(rx_valid),         64'd0);

    // Backpressure: six matches against a four-entry buffer.
    for (int i = 0; i < 6; i++) begin
      bp[i] = mk(8'h00, 4'd1, 4'd1, 1'b0, 23'h000A00 + 23'(i));
      push(bp[i]);
    end
    run_cycles(40, pops, vn);
    check("bp_pops",  64'(pops), 64'd4);
    check("bp_full",  64'(full), 64'd1);
    check("bp_pop_0", 64'(pop),  64'd0);
    run_cycles(9, pops, vn);
    check("bp_stall_pops", 64'(pops),    64'd0);
    check("bp_head0",      64'(rx_data), 64'(bp[0]));
    read_one();
    check("bp_full_clr",   64'(full),    64'd0);
    run_cycles(6, pops, vn);
    check("bp_fifth_pop",  64'(pops),    64'd1);
    check("bp_full_again", 64'(full),    64'd1);
    for (int k = 1; k < 6; k++) begin
      for (int w = 0; w < 10 && !rx_valid; w++) @(negedge clk);
      check($sformatf("bp_order%0d", k), 64'(rx_data), 64'(bp[k]));
      read_one();
    end
    repeat (6) @(negedge clk);
    check("bp_empty", 64'(rx_valid), 64'd0);

    // Read and write on the same edge with two entries held.
    pa = mk(8'h01, 4'd1, 4'd1, 1'b0, 23'h00B001);
    pb = mk(8'h02, 4'd1, 4'd1, 1'b0, 23'h00B002);
    pc = {22'h3FFFFF, 18'h0B003};
    push(pa);
    push(pb);
    run_cycles(10, pops, vn);
    check("sim_pre_pops", 64'(pops),    64'd2);
    check("sim_head_a",   64'(rx_data), 64'(pa));
    push(pc);
    wait_pop("sim");
    read_one();
    check("sim_valid",  64'(rx_valid), 64'd1);
    check("sim_head_b", 64'(rx_data),  64'(pb));
    check("sim_full",   64'(full),     64'd0);
    read_one();
    check("sim_head_c", 64'(rx_data),  64'(pc));
    check("sim_bcst_c", 64'(rx_bcst),  64'd1);
    read_one();
    check("sim_empty",  64'(rx_valid), 64'd0);

    // Reset asserted in the middle of a POP cycle.
    pa = mk(8'h00, 4'd1, 4'd1, 1'b0, 23'h00C001);
    pb = mk(8'h00, 4'd1, 4'd1, 1'b0, 23'h00C002);
    push(pa);
    run_cycles(6, pops, vn);
    check("rstp_pre_valid", 64'(rx_valid), 64'd1);
    push(pb);
    wait_pop("rstp");
    #2;
    reset = 1'b0;
    #1;
    check("rstp_pop",      64'(pop),          64'd0);
    check("rstp_rx_valid", 64'(rx_valid),     64'd0);
    check("rstp_misroute", 64'(misroute_cnt), 64'd0);
    check("rstp_full",     64'(full),         64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstp_rel_pop", 64'(pop), 64'd0);
    run_cycles(8, pops, vn);
    check("rstp_resume_pops", 64'(pops),     64'd1);
    check("rstp_resume_vld",  64'(rx_valid), 64'd1);
    check("rstp_resume_data", 64'(rx_data),  64'(pb));
    read_one();
    check("rstp_empty", 64'(rx_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
